mpsoc_sysid_arbiter: RTL

- Round-robin read arbiter that shares the single system-ID control slave (1-bit address, 32-bit combinational readdata) between the NUM_MASTERS processor data masters of the MPSoC.
- Sits between the per-CPU Avalon-MM read ports and the sysid slave.
- Serialises accesses, holds the slave address stable for a configurable latency, then returns registered read data to the winning master with a one-cycle readdatavalid pulse.
- Read-only: no write path exists.

---
 rtl/mpsoc_arb_pkg.sv | 21 ++
 rtl/mpsoc_rr_pick.sv | 27 ++
 rtl/mpsoc_sysid_arbiter.sv | 104 ++++++++++
 3 files changed

// File: rtl/mpsoc_arb_pkg.sv
// Shared types and helpers for the MPSoC shared-slave read arbiters.
// Provides the arbiter state encoding, the latency counter width and an index-width helper.
package mpsoc_arb_pkg;

  localparam int LAT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } arb_state_e;

  // Never returns less than 1 so a two-master arbiter still gets a real index bit.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/mpsoc_rr_pick.sv
// Combinational round-robin picker: grants the first requester found after ptr, wrapping at N.
// Intended for reuse by every shared-slave arbiter in the MPSoC.
module mpsoc_rr_pick
  import mpsoc_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] winner,
  output logic             any_req
);

  // The last master served sits at ptr, so it is examined last (k == N).
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!any_req && req[(int'(ptr) + k) % N]) begin
        winner  = IDX_W'((int'(ptr) + k) % N);
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mpsoc_sysid_arbiter.sv
// Round-robin read arbiter sharing the system-ID slave between the MPSoC data masters.
// One access at a time: accept, hold the slave address for the configured latency, return registered data.
module mpsoc_sysid_arbiter
  import mpsoc_arb_pkg::*;
#(
  parameter int NUM_MASTERS   = 4,
  parameter int ADDR_W        = 1,
  parameter int DATA_W        = 32,
  parameter int SLAVE_LATENCY = 0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_MASTERS-1:0]        m_read,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_address,
  output logic [NUM_MASTERS-1:0]        m_waitrequest,
  output logic [NUM_MASTERS-1:0]        m_readdatavalid,
  output logic [DATA_W-1:0]             m_readdata,
  output logic [ADDR_W-1:0]             s_address,
  output logic                          s_read,
  input  logic [DATA_W-1:0]             s_readdata,
  output logic                          busy
);

  localparam int GRANT_W = clog2(NUM_MASTERS);

  // Latencies beyond the counter range saturate; the assertion below flags the misconfiguration.
  localparam logic [LAT_CNT_W-1:0] LAT_INIT =
    (SLAVE_LATENCY > 15) ? {LAT_CNT_W{1'b1}} : LAT_CNT_W'(SLAVE_LATENCY);

  arb_state_e           state;
  arb_state_e           next_state;
  logic [GRANT_W-1:0]   rr_ptr;
  logic [GRANT_W-1:0]   grant_q;
  logic [GRANT_W-1:0]   winner;
  logic                 any_req;
  logic [ADDR_W-1:0]    addr_q;
  logic [LAT_CNT_W-1:0] lat_cnt;
  logic [DATA_W-1:0]    rdata_q;

  mpsoc_rr_pick #(
    .N     (NUM_MASTERS),
    .IDX_W (GRANT_W)
  ) u_pick (
    .req     (m_read),
    .ptr     (rr_ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_req) next_state = WAIT;
      WAIT:    if (lat_cnt == '0) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Acceptance is signalled combinationally so the winner sees it in its request cycle.
  always_comb begin
    m_waitrequest   = '1;
    m_readdatavalid = '0;
    if (!reset && state == IDLE && any_req) m_waitrequest[winner] = 1'b0;
    if (state == RESP) m_readdatavalid[grant_q] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      rr_ptr  <= GRANT_W'(NUM_MASTERS - 1);
      grant_q <= '0;
      addr_q  <= '0;
      lat_cnt <= '0;
      rdata_q <= '0;
      s_read  <= 1'b0;
    end else begin
      state  <= next_state;
      s_read <= (next_state == WAIT);
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_q <= winner;
            addr_q  <= m_address[winner*ADDR_W +: ADDR_W];
            lat_cnt <= LAT_INIT;
          end
        end
        WAIT: begin
          if (lat_cnt == '0) rdata_q <= s_readdata;
          else               lat_cnt <= lat_cnt - LAT_CNT_W'(1);
        end
        RESP:    rr_ptr <= grant_q;
        default: ;
      endcase
    end
  end

  assign s_address  = addr_q;
  assign m_readdata = rdata_q;
  assign busy       = (state != IDLE);

  lat_range_check: assert property (@(posedge clock) SLAVE_LATENCY <= 15);

endmodule
